agc_output_stage: RTL and testbench
===================================

Name: agc_output_stage

Overview:
- Downstream of the AGC loop; consumes its 26-bit I/Q output and Valid_Out.
- Rounds and saturates each sample to W_OUT bits.
- Buffers samples in a small show-ahead FIFO with valid/ready toward the consumer, because the AGC cannot stall.
- Runs a lock detector (ACQUIRE/LOCKED) on output magnitude versus the R_level target, and keeps saturation/overflow statistics.

Parameters:
- W_IN_MODULE, 26, input sample width (signed)
- W_OUT, 16, output sample width (signed)
- RWIDTH, 8, R_level width
- SHIFT, 0, arithmetic right shift applied before saturation, round-half-up
- FIFO_DEPTH, 4, output FIFO depth, power of 2, >=2
- LOCK_COUNT, 16, consecutive in-window samples to declare lock
- UNLOCK_COUNT, 8, consecutive out-of-window samples to lose lock
- CNTWIDTH, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample strobe (AGC Valid_Out)
- s_dataI  in  W_IN_MODULE  signed I sample
- s_dataQ  in  W_IN_MODULE  signed Q sample
- R_level  in  RWIDTH  target level, same value as fed to the AGC
- Lock_Tol  in  W_OUT  unsigned lock window half-width
- clr_stats  in  1  synchronous clear of flags and counters
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_dataI  out  W_OUT  signed I output
- m_dataQ  out  W_OUT  signed Q output
- locked  out  1  lock state
- sat_flag  out  1  sticky: any component saturated
- sat_count  out  CNTWIDTH  saturated samples, saturating counter
- ovf_flag  out  1  sticky: sample dropped on full FIFO
- ovf_count  out  CNTWIDTH  dropped samples, saturating counter

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, m_valid=0, m_dataI/Q=0, locked=0, state ACQUIRE, hit/miss counters=0, all flags and counts=0, stage register invalid. Reset mid-operation discards buffered samples.
- Stage 1 (registered on s_valid):
  - r = (x + 2^(SHIFT-1)) >>> SHIFT; no rounding term when SHIFT=0.
  - Saturate r to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - Compute mag = |I_sat| + |Q_sat|, W_OUT+1 bits unsigned, with |-32768| = 32768.
  - Set sat_hit if either component was clipped.
  - s_valid low: stage register keeps its data, valid=0.
- Stage 2:
  - A valid stage-1 sample is written to the FIFO at the next edge.
  - Latency s_valid edge to m_valid high is 2 clocks when the FIFO is empty.
- FIFO:
  - Show-ahead; m_dataI/Q show the head combinationally from the FIFO registers.
  - A pop occurs on an edge where m_valid && m_ready.
  - Full means count==FIFO_DEPTH.
  - A write while full is accepted only if a pop occurs the same edge. Otherwise the sample is dropped: ovf_flag=1, ovf_count++.
  - Simultaneous push and pop leaves count unchanged.
  - m_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Target and window:
  - Target T = {R_level, (W_OUT-RWIDTH) zeros}, unsigned.
  - in_window = |mag - T| <= Lock_Tol.
- Lock FSM, updated once per valid stage-1 sample, independent of FIFO drops:
  - ACQUIRE: in_window increments hit, otherwise hit=0. When hit reaches LOCK_COUNT, go to LOCKED with hit=0 and miss=0.
  - LOCKED: out of window increments miss, otherwise miss=0. When miss reaches UNLOCK_COUNT, go to ACQUIRE with miss=0.
  - locked=1 exactly in LOCKED, registered. It rises on the edge that consumes the LOCK_COUNT-th hit.
- Statistics:
  - On a valid sample with sat_hit: sat_flag=1 and sat_count++, saturating at all-ones.
  - clr_stats zeroes the flags and counts; if an event occurs in the same cycle, clear wins.
  - clr_stats does not affect the FIFO or lock FSM.
- Lock_Tol and R_level may change anytime; they apply to the next evaluated sample.

Decomposition:
- Shared package agc_pkg: lock state encoding (ACQUIRE=0, LOCKED=1), round/saturate width constants, target-construction function (R_level zero-extension).
- One sub-module, agc_out_fifo: a parameterized show-ahead FIFO (data width 2*W_OUT, depth FIFO_DEPTH) exposing full, empty and count.
- Rounding, saturation, magnitude and FSM stay in the top module.

Test Plan:
- Saturation/latency: m_ready=1; one s_valid with I=40000, Q=-40000 -> m_dataI=32767, m_dataQ=-32768, m_valid high exactly 2 clocks later for 1 cycle; sat_flag=1, sat_count=1.
- Rounding (SHIFT=2 build): I=6, Q=-6 -> m_dataI=2, m_dataQ=-1; I=5 -> 1; no saturation.
- Lock: R_level=0x40 (T=16384), Lock_Tol=512; 16 samples I=16384, Q=0 -> locked rises on the edge after the 16th sample reaches stage 1. Then 7 samples I=8000 -> stays locked. One in-window sample resets miss, then 8 samples I=8000 -> locked=0.
- Overflow: m_ready=0, 6 consecutive samples -> 4 buffered, ovf_count=2, ovf_flag=1. Then m_ready=1 -> first 4 samples emerge in order, then m_valid=0.
- Full with simultaneous pop: FIFO full, m_ready=1 and s_valid each cycle -> no drops, count stays 4, sequence intact.
- Reset/clear: assert rst_n=0 mid-stream with FIFO holding 3 samples -> m_valid=0, locked=0, counts 0 immediately. clr_stats coinciding with a saturating sample -> sat_count=0, sat_flag=0.

Source files
------------

// File: rtl/agc_pkg.sv
// agc_pkg
// Shared definitions for the AGC output stage:
//   - default sample widths used by the top-level parameters
//   - lock-detector state encoding
//   - make_target(): builds the lock target by placing R_level at the top
//     of a W_OUT-bit unsigned word (zero fill below)
package agc_pkg;

  localparam int AGC_W_IN   = 26;
  localparam int AGC_W_OUT  = 16;
  localparam int AGC_RWIDTH = 8;

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_LOCKED  = 1'b1;

  // Result is kept 32 bits wide so the window arithmetic downstream can be
  // done without truncation, whatever W_OUT is.
  function automatic logic [31:0] make_target(input logic [31:0] r_level,
                                              input int          rwidth,
                                              input int          w_out);
    logic [31:0] mask;
    mask = (32'd1 << rwidth) - 32'd1;
    return (r_level & mask) << (w_out - rwidth);
  endfunction

endpackage

// File: rtl/agc_out_fifo.sv
// agc_out_fifo
// Show-ahead FIFO: rd_data always presents the entry at the read pointer,
// a read (rd_en while not empty) just advances past it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      push request and data
//   rd_en               pop request (ignored while empty)
//   rd_data             current head entry
//   full, empty, count  occupancy status
// A push while full is accepted only when a pop happens on the same edge.
module agc_out_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
  always_comb begin
    do_pop   = rd_en && !empty;
    do_push  = wr_en && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/agc_output_stage.sv
// agc_output_stage
// Post-AGC output conditioning: round/saturate I/Q to W_OUT bits, buffer in
// a show-ahead FIFO toward a valid/ready consumer, detect lock on output
// magnitude against the R_level target, and keep saturation/overflow stats.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   s_valid, s_dataI/Q       AGC sample strobe and signed samples
//   R_level, Lock_Tol        lock target level and window half-width
//   clr_stats                synchronous clear of flags and counters
//   m_valid, m_ready         output handshake (FIFO head)
//   m_dataI/Q                head sample
//   locked                   lock detector state
//   sat_flag, sat_count      sticky clip flag, saturating clip counter
//   ovf_flag, ovf_count      sticky drop flag, saturating drop counter
module agc_output_stage
  import agc_pkg::*;
#(
  parameter int W_IN_MODULE  = AGC_W_IN,
  parameter int W_OUT        = AGC_W_OUT,
  parameter int RWIDTH       = AGC_RWIDTH,
  parameter int SHIFT        = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNTWIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic signed [W_IN_MODULE-1:0] s_dataI,
  input  logic signed [W_IN_MODULE-1:0] s_dataQ,
  input  logic        [RWIDTH-1:0]      R_level,
  input  logic        [W_OUT-1:0]       Lock_Tol,
  input  logic                          clr_stats,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [W_OUT-1:0]       m_dataI,
  output logic signed [W_OUT-1:0]       m_dataQ,
  output logic                          locked,
  output logic                          sat_flag,
  output logic        [CNTWIDTH-1:0]    sat_count,
  output logic                          ovf_flag,
  output logic        [CNTWIDTH-1:0]    ovf_count
);

  localparam int W_R = W_IN_MODULE + 1;
  localparam int HW  = $clog2(LOCK_COUNT + 1);
  localparam int MW  = $clog2(UNLOCK_COUNT + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  // (1<<SHIFT)>>1 gives the half-LSB rounding term and is 0 when SHIFT==0.
  localparam logic signed [W_R-1:0]   RND     = W_R'((1 << SHIFT) >> 1);
  localparam logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};
  localparam logic [HW-1:0]           HIT_LAST  = HW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]           MISS_LAST = MW'(UNLOCK_COUNT - 1);

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic signed [W_OUT-1:0] round_sat(
      input  logic signed [W_IN_MODULE-1:0] x,
      output logic                          clip);
    logic signed [W_R-1:0]   r;
    logic signed [W_OUT-1:0] res;
    r    = $signed({x[W_IN_MODULE-1], x}) + RND;
    r    = r >>> SHIFT;
    clip = 1'b1;
    if (r > W_R'(OUT_MAX)) begin
      res = OUT_MAX;
    end else if (r < W_R'(OUT_MIN)) begin
      res = OUT_MIN;
    end else begin
      res  = r[W_OUT-1:0];
      clip = 1'b0;
    end
    return res;
  endfunction

  // Absolute value one bit wider so the most negative code maps cleanly.
  function automatic logic [W_OUT:0] abs_ext(input logic signed [W_OUT-1:0] v);
    logic [W_OUT:0] e;
    e = {v[W_OUT-1], v};
    return v[W_OUT-1] ? (~e + 1'b1) : e;
  endfunction

  logic                    st_valid_q, st_valid_d;
  logic signed [W_OUT-1:0] st_i_q, st_i_d, st_q_q, st_q_d;
  logic [W_OUT:0]          st_mag_q, st_mag_d;
  logic                    st_sat_q, st_sat_d;
  logic signed [W_OUT-1:0] sat_i, sat_q;
  logic                    clip_i, clip_q;

  logic [0:0]              state_q, state_d;
  logic [HW-1:0]           hit_q, hit_d;
  logic [MW-1:0]           miss_q, miss_d;
  logic [31:0]             target, mag_ext, diff;
  logic                    in_window;

  logic                    sat_flag_q, sat_flag_d, ovf_flag_q, ovf_flag_d;
  logic [CNTWIDTH-1:0]     sat_count_q, sat_count_d, ovf_count_q, ovf_count_d;
  logic                    sat_ev, ovf_ev;

  logic                    fifo_full, fifo_empty, fifo_wr, pop;
  logic [FCW-1:0]          fifo_count;
  logic [2*W_OUT-1:0]      fifo_rd_data;

  // Stage 1: condition the incoming sample; data holds when s_valid is low.
  always_comb begin
    clip_i     = 1'b0;
    clip_q     = 1'b0;
    sat_i      = round_sat(s_dataI, clip_i);
    sat_q      = round_sat(s_dataQ, clip_q);
    st_valid_d = s_valid;
    st_i_d     = st_i_q;
    st_q_d     = st_q_q;
    st_mag_d   = st_mag_q;
    st_sat_d   = st_sat_q;
    if (s_valid) begin
      st_i_d   = sat_i;
      st_q_d   = sat_q;
      st_mag_d = abs_ext(sat_i) + abs_ext(sat_q);
      st_sat_d = clip_i || clip_q;
    end
  end

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign fifo_wr = st_valid_q && (!fifo_full || pop);
  assign m_dataI = fifo_rd_data[2*W_OUT-1:W_OUT];
  assign m_dataQ = fifo_rd_data[W_OUT-1:0];

  agc_out_fifo #(
    .DW    (2*W_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({st_i_q, st_q_q}),
    .rd_en   (m_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Lock detector runs on every valid stage sample, even ones the FIFO drops.
  // R_level/Lock_Tol are read live, so changes take effect on the next sample.
  always_comb begin
    target    = make_target(32'(R_level), RWIDTH, W_OUT);
    mag_ext   = 32'(st_mag_q);
    diff      = (mag_ext >= target) ? (mag_ext - target) : (target - mag_ext);
    in_window = (diff <= 32'(Lock_Tol));
    state_d   = state_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    if (st_valid_q) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!in_window) begin
            hit_d = '0;
          end else if (hit_q == HIT_LAST) begin
            state_d = ST_LOCKED;
            hit_d   = '0;
            miss_d  = '0;
          end else begin
            hit_d = hit_q + 1'b1;
          end
        end
        default: begin
          if (in_window) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d = ST_ACQUIRE;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign locked = (state_q == ST_LOCKED);

  // Statistics: counters stick at all-ones; a clear beats a same-cycle event.
  always_comb begin
    sat_ev      = st_valid_q && st_sat_q;
    ovf_ev      = st_valid_q && (fifo_count == FCW'(FIFO_DEPTH)) && !pop;
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    ovf_flag_d  = ovf_flag_q;
    ovf_count_d = ovf_count_q;
    if (clr_stats) begin
      sat_flag_d  = 1'b0;
      sat_count_d = '0;
      ovf_flag_d  = 1'b0;
      ovf_count_d = '0;
    end else begin
      if (sat_ev) begin
        sat_flag_d = 1'b1;
        if (sat_count_q != '1) sat_count_d = sat_count_q + 1'b1;
      end
      if (ovf_ev) begin
        ovf_flag_d = 1'b1;
        if (ovf_count_q != '1) ovf_count_d = ovf_count_q + 1'b1;
      end
    end
  end

  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;
  assign ovf_flag  = ovf_flag_q;
  assign ovf_count = ovf_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q  <= 1'b0;
      st_i_q      <= '0;
      st_q_q      <= '0;
      st_mag_q    <= '0;
      st_sat_q    <= 1'b0;
      state_q     <= ST_ACQUIRE;
      hit_q       <= '0;
      miss_q      <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
      ovf_flag_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      st_valid_q  <= st_valid_d;
      st_i_q      <= st_i_d;
      st_q_q      <= st_q_d;
      st_mag_q    <= st_mag_d;
      st_sat_q    <= st_sat_d;
      state_q     <= state_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
      ovf_flag_q  <= ovf_flag_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_agc_output_stage.sv
// tb_agc_output_stage
// Directed bench for agc_output_stage. The main instance uses default
// parameters; a second instance built with SHIFT=2 exercises rounding.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at the same point, so every check sees settled post-edge state.
module tb_agc_output_stage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid;
  logic signed [25:0] s_dataI, s_dataQ;
  logic [7:0]         R_level;
  logic [15:0]        Lock_Tol;
  logic               clr_stats;
  logic               m_valid, m_ready;
  logic signed [15:0] m_dataI, m_dataQ;
  logic               locked, sat_flag, ovf_flag;
  logic [15:0]        sat_count, ovf_count;

  logic               s_valid2;
  logic signed [25:0] s_dataI2, s_dataQ2;
  logic               m_valid2, locked2, sat_flag2, ovf_flag2;
  logic signed [15:0] m_dataI2, m_dataQ2;
  logic [15:0]        sat_count2, ovf_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  agc_output_stage dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_dataI(s_dataI),
    .s_dataQ(s_dataQ), .R_level(R_level), .Lock_Tol(Lock_Tol),
    .clr_stats(clr_stats), .m_valid(m_valid), .m_ready(m_ready),
    .m_dataI(m_dataI), .m_dataQ(m_dataQ), .locked(locked),
    .sat_flag(sat_flag), .sat_count(sat_count), .ovf_flag(ovf_flag),
    .ovf_count(ovf_count)
  );

  agc_output_stage #(.SHIFT(2)) dut_rnd (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_dataI(s_dataI2),
    .s_dataQ(s_dataQ2), .R_level(R_level), .Lock_Tol(Lock_Tol),
    .clr_stats(clr_stats), .m_valid(m_valid2), .m_ready(m_ready),
    .m_dataI(m_dataI2), .m_dataQ(m_dataQ2), .locked(locked2),
    .sat_flag(sat_flag2), .sat_count(sat_count2), .ovf_flag(ovf_flag2),
    .ovf_count(ovf_count2)
  );

  // Drive one sample (or an idle slot) into the main instance, then step
  // past the next rising edge.
  task automatic applyStimulus(input logic v, input int i, input int q);
    s_valid = v;
    s_dataI = 26'(i);
    s_dataQ = 26'(q);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_dataI = '0; s_dataQ = '0;
    s_valid2 = 1'b0; s_dataI2 = '0; s_dataQ2 = '0;
    R_level = 8'h00; Lock_Tol = 16'd0; clr_stats = 1'b0; m_ready = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_m_dataI", $signed(m_dataI), 0);
    checkOutput("rst_sat_count", sat_count, 0);
    checkOutput("rst_ovf_flag", ovf_flag, 0);
    applyStimulus(0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);

    // Saturation and 2-clock latency
    $display("[TB] saturation / latency");
    m_ready = 1'b1;
    applyStimulus(1, 40000, -40000);
    checkOutput("lat_not_yet", m_valid, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lat_m_valid", m_valid, 1);
    checkOutput("sat_dataI", $signed(m_dataI), 32767);
    checkOutput("sat_dataQ", $signed(m_dataQ), -32768);
    checkOutput("sat_flag", sat_flag, 1);
    checkOutput("sat_count", sat_count, 1);
    applyStimulus(0, 0, 0);
    checkOutput("lat_one_cycle", m_valid, 0);

    // Rounding on the SHIFT=2 instance
    $display("[TB] rounding");
    s_valid2 = 1'b1; s_dataI2 = 26'sd6; s_dataQ2 = -26'sd6;
    applyStimulus(0, 0, 0);
    s_dataI2 = 26'sd5; s_dataQ2 = -26'sd7;
    applyStimulus(0, 0, 0);
    s_valid2 = 1'b0;
    checkOutput("rnd_valid_a", m_valid2, 1);
    checkOutput("rnd_I_6", $signed(m_dataI2), 2);
    checkOutput("rnd_Q_m6", $signed(m_dataQ2), -1);
    applyStimulus(0, 0, 0);
    checkOutput("rnd_I_5", $signed(m_dataI2), 1);
    checkOutput("rnd_Q_m7", $signed(m_dataQ2), -2);
    checkOutput("rnd_no_sat", sat_flag2, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rnd_drained", m_valid2, 0);
    checkOutput("rnd_no_ovf", ovf_count2, 0);
    checkOutput("rnd_unlocked", locked2, 0);

    // Lock acquisition and loss
    $display("[TB] lock detector");
    R_level = 8'h40; Lock_Tol = 16'd512;
    for (int k = 0; k < 16; k++) applyStimulus(1, 16384, 0);
    checkOutput("lock_before", locked, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lock_rise", locked, 1);
    for (int k = 0; k < 7; k++) applyStimulus(1, 8000, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lock_7_miss", locked, 1);
    applyStimulus(1, 16384, 0);
    for (int k = 0; k < 7; k++) applyStimulus(1, 8000, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lock_miss_reset", locked, 1);
    applyStimulus(1, 8000, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lock_lost", locked, 0);

    // Overflow with consumer stalled
    $display("[TB] overflow");
    clr_stats = 1'b1;
    applyStimulus(0, 0, 0);
    clr_stats = 1'b0;
    checkOutput("clr_sat_flag", sat_flag, 0);
    checkOutput("clr_sat_count", sat_count, 0);
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(1, 100 + k, -(100 + k));
    applyStimulus(0, 0, 0);
    checkOutput("ovf_count", ovf_count, 2);
    checkOutput("ovf_flag", ovf_flag, 1);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("ovf_drain_valid", m_valid, 1);
      checkOutput("ovf_drain_I", $signed(m_dataI), 100 + k);
      checkOutput("ovf_drain_Q", $signed(m_dataQ), -(100 + k));
      applyStimulus(0, 0, 0);
    end
    checkOutput("ovf_empty", m_valid, 0);

    // Full FIFO with simultaneous push and pop
    $display("[TB] full with pop");
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1, 200 + k, 0);
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("full_head", $signed(m_dataI), 200 + k);
      applyStimulus(1, 205 + k, 0);
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("full_tail", $signed(m_dataI), 206 + k);
      applyStimulus(0, 0, 0);
    end
    checkOutput("full_empty", m_valid, 0);
    checkOutput("full_no_drop", ovf_count, 2);

    // Asynchronous reset mid-stream
    $display("[TB] reset mid-stream");
    for (int k = 0; k < 16; k++) applyStimulus(1, 16384, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rs_locked", locked, 1);
    applyStimulus(1, 40000, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rs_sat_count", sat_count, 1);
    applyStimulus(0, 0, 0);
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1, k + 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rs_buffered", m_valid, 1);
    checkOutput("rs_head", $signed(m_dataI), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_m_valid", m_valid, 0);
    checkOutput("rs_locked0", locked, 0);
    checkOutput("rs_sat0", sat_count, 0);
    checkOutput("rs_ovf0", ovf_count, 0);
    checkOutput("rs_ovf_flag0", ovf_flag, 0);
    checkOutput("rs_dataI0", $signed(m_dataI), 0);
    applyStimulus(0, 0, 0);
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("rs_no_leftover", m_valid, 0);
    applyStimulus(1, 77, -77);
    applyStimulus(0, 0, 0);
    checkOutput("rs_new_sample", $signed(m_dataI), 77);

    // Clear colliding with a saturating sample
    $display("[TB] clear vs event");
    applyStimulus(1, 40000, 0);
    clr_stats = 1'b1;
    applyStimulus(0, 0, 0);
    clr_stats = 1'b0;
    checkOutput("clr_wins_flag", sat_flag, 0);
    checkOutput("clr_wins_count", sat_count, 0);
    checkOutput("clr_fifo_kept", $signed(m_dataI), 32767);
    applyStimulus(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
